// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with flush, bubble and hold handling.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ALUOP_W   = 8,
    parameter int unsigned ALUSEL_W  = 3,
    parameter int unsigned STALL_IDX = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          control,
    input  logic                flush,
`ifdef ID_EX_PERF_CNT_EN
    input  logic                perf_clr,
`endif
    input  logic                id_valid,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_op1,
    input  logic [DATA_W-1:0]   id_op2,
    input  logic [ADDR_W-1:0]   id_dest,
    input  logic                id_wreg,
    input  logic                id_in_delayslot,
    input  logic                id_next_delay,
    input  logic [DATA_W-1:0]   id_ret_addr,
    input  logic [DATA_W-1:0]   id_ins,
    output logic                ex_valid,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_op1,
    output logic [DATA_W-1:0]   ex_op2,
    output logic [ADDR_W-1:0]   ex_dest,
    output logic                ex_wreg,
    output logic                ex_in_delayslot,
    output logic [DATA_W-1:0]   ex_ret_addr,
    output logic [DATA_W-1:0]   ex_ins,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
`endif
    output logic                id_is_in_delayslot
);

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } action_e;

    logic [1:0] stall_pair;
    logic       stall_id;
    logic       stall_ex;
    action_e    action;

    // Only this stage's bit and the execute bit matter; the rest of the vector is shifted away.
    assign stall_pair = 2'(control >> STALL_IDX);
    assign stall_id   = stall_pair[0];
    assign stall_ex   = stall_pair[1];

    always_comb begin
        action = ACT_CAPTURE;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (stall_id && !stall_ex) begin
            action = ACT_BUBBLE;
        end else if (stall_id) begin
            action = ACT_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid           <= 1'b0;
            ex_aluop           <= '0;
            ex_alusel          <= '0;
            ex_op1             <= '0;
            ex_op2             <= '0;
            ex_dest            <= '0;
            ex_wreg            <= 1'b0;
            ex_in_delayslot    <= 1'b0;
            ex_ret_addr        <= '0;
            ex_ins             <= '0;
            id_is_in_delayslot <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    ex_valid        <= 1'b0;
                    ex_aluop        <= '0;
                    ex_alusel       <= '0;
                    ex_op1          <= '0;
                    ex_op2          <= '0;
                    ex_dest         <= '0;
                    ex_wreg         <= 1'b0;
                    ex_in_delayslot <= 1'b0;
                    ex_ret_addr     <= '0;
                    ex_ins          <= '0;
                    // A bubble keeps the delay-slot feedback; a flush discards it.
                    if (action == ACT_FLUSH) begin
                        id_is_in_delayslot <= 1'b0;
                    end
                end
                ACT_CAPTURE: begin
                    ex_valid           <= id_valid;
                    ex_aluop           <= id_aluop;
                    ex_alusel          <= id_alusel;
                    ex_op1             <= id_op1;
                    ex_op2             <= id_op2;
                    ex_dest            <= id_dest;
                    ex_wreg            <= id_wreg;
                    ex_in_delayslot    <= id_in_delayslot;
                    ex_ret_addr        <= id_ret_addr;
                    ex_ins             <= id_ins;
                    id_is_in_delayslot <= id_next_delay;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating event counters; clear wins over any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall_id && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (action == ACT_BUBBLE && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (action == ACT_FLUSH && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (32-bit/STALL_IDX=2 and 64-bit/STALL_IDX=4)
// checked every cycle against a rule-level model; counters checked when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        perf_clr;
    logic        stall_id;
    logic        stall_ex;
    logic [5:0]  noise;
    logic [5:0]  ctl_a;
    logic [5:0]  ctl_b;
    logic        valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  dest;
    logic        wreg;
    logic        in_ds;
    logic        next_delay;
    logic [63:0] ret_addr;
    logic [63:0] ins;

    logic        ex_valid_a, ex_wreg_a, ex_in_ds_a, ds_fb_a;
    logic [7:0]  ex_aluop_a;
    logic [2:0]  ex_alusel_a;
    logic [31:0] ex_op1_a, ex_op2_a, ex_ret_a, ex_ins_a;
    logic [4:0]  ex_dest_a;
    logic        ex_valid_b, ex_wreg_b, ex_in_ds_b, ds_fb_b;
    logic [7:0]  ex_aluop_b;
    logic [2:0]  ex_alusel_b;
    logic [63:0] ex_op1_b, ex_op2_b, ex_ret_b, ex_ins_b;
    logic [4:0]  ex_dest_b;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_a, bubble_cnt_a, flush_cnt_a;
    logic [3:0]  stall_cnt_b, bubble_cnt_b, flush_cnt_b;
`endif

    int checks = 0;
    int errors = 0;
    int notes  = 0;

    always #5 clk = ~clk;

    // Unrelated control bits are random noise; only the two stage bits are placed per instance.
    always_comb begin
        ctl_a    = noise;
        ctl_a[2] = stall_id;
        ctl_a[3] = stall_ex;
        ctl_b    = noise;
        ctl_b[4] = stall_id;
        ctl_b[5] = stall_ex;
    end

    id_ex_stage #(.CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .control(ctl_a), .flush(flush),
`ifdef ID_EX_PERF_CNT_EN
        .perf_clr(perf_clr),
`endif
        .id_valid(valid), .id_aluop(aluop), .id_alusel(alusel),
        .id_op1(op1[31:0]), .id_op2(op2[31:0]), .id_dest(dest), .id_wreg(wreg),
        .id_in_delayslot(in_ds), .id_next_delay(next_delay),
        .id_ret_addr(ret_addr[31:0]), .id_ins(ins[31:0]),
        .ex_valid(ex_valid_a), .ex_aluop(ex_aluop_a), .ex_alusel(ex_alusel_a),
        .ex_op1(ex_op1_a), .ex_op2(ex_op2_a), .ex_dest(ex_dest_a), .ex_wreg(ex_wreg_a),
        .ex_in_delayslot(ex_in_ds_a), .ex_ret_addr(ex_ret_a), .ex_ins(ex_ins_a),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt_a), .bubble_cnt(bubble_cnt_a), .flush_cnt(flush_cnt_a),
`endif
        .id_is_in_delayslot(ds_fb_a)
    );

    id_ex_stage #(.DATA_W(64), .STALL_IDX(4), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .control(ctl_b), .flush(flush),
`ifdef ID_EX_PERF_CNT_EN
        .perf_clr(perf_clr),
`endif
        .id_valid(valid), .id_aluop(aluop), .id_alusel(alusel),
        .id_op1(op1), .id_op2(op2), .id_dest(dest), .id_wreg(wreg),
        .id_in_delayslot(in_ds), .id_next_delay(next_delay),
        .id_ret_addr(ret_addr), .id_ins(ins),
        .ex_valid(ex_valid_b), .ex_aluop(ex_aluop_b), .ex_alusel(ex_alusel_b),
        .ex_op1(ex_op1_b), .ex_op2(ex_op2_b), .ex_dest(ex_dest_b), .ex_wreg(ex_wreg_b),
        .ex_in_delayslot(ex_in_ds_b), .ex_ret_addr(ex_ret_b), .ex_ins(ex_ins_b),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt_b), .bubble_cnt(bubble_cnt_b), .flush_cnt(flush_cnt_b),
`endif
        .id_is_in_delayslot(ds_fb_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [4:0]  dest;
        logic        wreg;
        logic        in_ds;
        logic [63:0] ret;
        logic [63:0] ins;
        logic        ds_fb;
    } model_t;

    model_t m;
    bit     started = 0;
    int     sc = 0;
    int     bc = 0;
    int     fc = 0;

    function automatic logic [63:0] sat(input int v, input int lim);
        return 64'((v > lim) ? lim : v);
    endfunction

    task automatic cmp_all();
        chk("a.ex_valid",  64'(ex_valid_a),  64'(m.valid));
        chk("a.ex_aluop",  64'(ex_aluop_a),  64'(m.aluop));
        chk("a.ex_alusel", 64'(ex_alusel_a), 64'(m.alusel));
        chk("a.ex_op1",    64'(ex_op1_a),    64'(m.op1[31:0]));
        chk("a.ex_op2",    64'(ex_op2_a),    64'(m.op2[31:0]));
        chk("a.ex_dest",   64'(ex_dest_a),   64'(m.dest));
        chk("a.ex_wreg",   64'(ex_wreg_a),   64'(m.wreg));
        chk("a.ex_in_ds",  64'(ex_in_ds_a),  64'(m.in_ds));
        chk("a.ex_ret",    64'(ex_ret_a),    64'(m.ret[31:0]));
        chk("a.ex_ins",    64'(ex_ins_a),    64'(m.ins[31:0]));
        chk("a.ds_fb",     64'(ds_fb_a),     64'(m.ds_fb));
        chk("b.ex_valid",  64'(ex_valid_b),  64'(m.valid));
        chk("b.ex_aluop",  64'(ex_aluop_b),  64'(m.aluop));
        chk("b.ex_alusel", 64'(ex_alusel_b), 64'(m.alusel));
        chk("b.ex_op1",    ex_op1_b,         m.op1);
        chk("b.ex_op2",    ex_op2_b,         m.op2);
        chk("b.ex_dest",   64'(ex_dest_b),   64'(m.dest));
        chk("b.ex_wreg",   64'(ex_wreg_b),   64'(m.wreg));
        chk("b.ex_in_ds",  64'(ex_in_ds_b),  64'(m.in_ds));
        chk("b.ex_ret",    ex_ret_b,         m.ret);
        chk("b.ex_ins",    ex_ins_b,         m.ins);
        chk("b.ds_fb",     64'(ds_fb_b),     64'(m.ds_fb));
`ifdef ID_EX_PERF_CNT_EN
        chk("a.stall_cnt",  64'(stall_cnt_a),  sat(sc, 65535));
        chk("a.bubble_cnt", 64'(bubble_cnt_a), sat(bc, 65535));
        chk("a.flush_cnt",  64'(flush_cnt_a),  sat(fc, 65535));
        chk("b.stall_cnt",  64'(stall_cnt_b),  sat(sc, 15));
        chk("b.bubble_cnt", 64'(bubble_cnt_b), sat(bc, 15));
        chk("b.flush_cnt",  64'(flush_cnt_b),  sat(fc, 15));
`endif
    endtask

    // Model advances on the inputs seen at each edge; outputs are compared 1 time unit later.
    always @(posedge clk) begin
        if (rst) begin
            m       = '0;
            sc      = 0;
            bc      = 0;
            fc      = 0;
            started = 1;
        end else if (started) begin
`ifdef ID_EX_PERF_CNT_EN
            if (perf_clr) begin
                sc = 0; bc = 0; fc = 0;
            end else if (flush) begin
                fc++;
            end else if (stall_id) begin
                sc++;
                if (!stall_ex) bc++;
            end
`endif
            if (flush) begin
                m = '0;
            end else if (stall_id && !stall_ex) begin
                m = '{ds_fb: m.ds_fb, default: '0};
            end else if (!stall_id) begin
                if (stall_ex) begin
                    notes++;
                    $display("note: capture while execute is stalled at %0t", $time);
                end
                m.valid  = valid;   m.aluop = aluop;   m.alusel = alusel;
                m.op1    = op1;     m.op2   = op2;     m.dest   = dest;
                m.wreg   = wreg;    m.in_ds = in_ds;   m.ret    = ret_addr;
                m.ins    = ins;     m.ds_fb = next_delay;
            end
        end
        #1;
        if (started) cmp_all();
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        noise = 6'($urandom);
    endtask

    task automatic rand_payload();
        valid    = 1'($urandom);
        aluop    = 8'($urandom);
        alusel   = 3'($urandom);
        op1      = {$urandom, $urandom};
        op2      = {$urandom, $urandom};
        dest     = 5'($urandom);
        wreg     = 1'($urandom);
        in_ds    = 1'($urandom);
        next_delay = 1'($urandom);
        ret_addr = {$urandom, $urandom};
        ins      = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; perf_clr = 1'b0;
        stall_id = 1'b0; stall_ex = 1'b0; noise = 6'h3f;
        rand_payload();
        cyc();
        chk("reset a.ex_valid", 64'(ex_valid_a), 64'd0);
        chk("reset a.ds_fb",    64'(ds_fb_a),    64'd0);
        chk("reset b.ex_op1",   ex_op1_b,        64'd0);

        // Reset then capture
        rst = 1'b0; rand_payload();
        valid = 1'b1; op1 = 64'h0000_0000_1234_5678; dest = 5'd5; wreg = 1'b1;
        cyc();
        chk("capture a.ex_op1",   64'(ex_op1_a),   64'h1234_5678);
        chk("capture a.ex_dest",  64'(ex_dest_a),  64'd5);
        chk("capture a.ex_wreg",  64'(ex_wreg_a),  64'd1);
        chk("capture a.ex_valid", 64'(ex_valid_a), 64'd1);
        chk("capture b.ex_op1",   ex_op1_b,        64'h1234_5678);
        chk("capture b.ex_dest",  64'(ex_dest_b),  64'd5);

        // Hold keeps the captured instruction while inputs churn
        rand_payload();
        valid = 1'b1; ins = 64'h0000_0000_AABB_CCDD; aluop = 8'h5A; next_delay = 1'b1;
        cyc();
        stall_id = 1'b1; stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            cyc();
            chk("hold a.ex_ins", 64'(ex_ins_a), 64'hAABB_CCDD);
            chk("hold b.ex_ins", ex_ins_b,      64'hAABB_CCDD);
        end

        // Bubble clears ex_* but keeps the delay-slot feedback
        stall_ex = 1'b0; valid = 1'b1; next_delay = 1'b0;
        cyc();
        chk("bubble a.ex_valid", 64'(ex_valid_a), 64'd0);
        chk("bubble a.ex_aluop", 64'(ex_aluop_a), 64'd0);
        chk("bubble a.ds_fb",    64'(ds_fb_a),    64'd1);
        chk("bubble b.ds_fb",    64'(ds_fb_b),    64'd1);

        // Flush wins over stall
        stall_ex = 1'b1; flush = 1'b1;
        cyc();
        chk("flush a.ex_op1", 64'(ex_op1_a), 64'd0);
        chk("flush b.ex_ins", ex_ins_b,      64'd0);
        chk("flush a.ds_fb",  64'(ds_fb_a),  64'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("flush a.flush_cnt", 64'(flush_cnt_a), 64'd1);
        chk("flush a.stall_cnt", 64'(stall_cnt_a), 64'd4);
        chk("flush b.bubble_cnt", 64'(bubble_cnt_b), 64'd1);
`endif
        flush = 1'b0;

        // Execute-stall alone does not stop capture
        stall_id = 1'b0; stall_ex = 1'b1; op1 = 64'hDEAD_BEEF_CAFE_F00D;
        cyc();
        chk("ex-only a.ex_op1", 64'(ex_op1_a), 64'hCAFE_F00D);
        chk("ex-only b.ex_op1", ex_op1_b,      64'hDEAD_BEEF_CAFE_F00D);

        // Reset during a hold discards the held contents
        stall_ex = 1'b0; op1 = 64'h1111;
        cyc();
        stall_id = 1'b1; stall_ex = 1'b1; op1 = 64'h9999;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst-in-hold a.ex_op1", 64'(ex_op1_a), 64'd0);
        rst = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; op1 = 64'h2222;
        cyc();
        chk("post-rst a.ex_op1", 64'(ex_op1_a), 64'h2222);
        chk("post-rst b.ex_op1", ex_op1_b,      64'h2222);

        // Counter saturation and clear
        stall_id = 1'b1; stall_ex = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
`ifdef ID_EX_PERF_CNT_EN
        chk("sat b.stall_cnt", 64'(stall_cnt_b), 64'd15);
        chk("sat a.stall_cnt", 64'(stall_cnt_a), 64'd20);
`endif
        perf_clr = 1'b1;
        cyc();
`ifdef ID_EX_PERF_CNT_EN
        chk("clr b.stall_cnt", 64'(stall_cnt_b), 64'd0);
        chk("clr a.stall_cnt", 64'(stall_cnt_a), 64'd0);
`endif
        perf_clr = 1'b0;

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            rand_payload();
            stall_id = ($urandom_range(0, 2) == 0);
            stall_ex = 1'($urandom);
            flush    = ($urandom_range(0, 7) == 0);
            perf_clr = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 29) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; perf_clr = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand/return-address/instruction width; ADDR_W, default 5, destination register address width; ALUOP_W, default 8, ALU opcode width; ALUSEL_W, default 3, ALU select width; STALL_IDX, default 2, this stage's bit in control (legal 0..4); CNT_W, default 16, performance counter width.
REQ-002 clk  in  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 control  in  6  stall vector; control[STALL_IDX] stalls this stage, control[STALL_IDX+1] stalls execute.
REQ-005 flush  in  1  discard this stage's contents (exception/redirect).
REQ-006 id_valid  in  1  decode holds a real instruction.
REQ-007 id_aluop / id_alusel  in  ALUOP_W / ALUSEL_W  decoded ALU opcode and select.
REQ-008 id_op1, id_op2  in  DATA_W each  source operands.
REQ-009 id_dest  in  ADDR_W  destination register; id_wreg  in  1  write enable.
REQ-010 id_in_delayslot  in  1  current decode instruction sits in a delay slot.
REQ-011 id_next_delay  in  1  next decode instruction will be in a delay slot.
REQ-012 id_ret_addr, id_ins  in  DATA_W each  link address and raw instruction word.
REQ-013 ex_valid, ex_aluop, ex_alusel, ex_op1, ex_op2, ex_dest, ex_wreg, ex_in_delayslot, ex_ret_addr, ex_ins  out  widths matching inputs  registered copies for execute.
REQ-014 id_is_in_delayslot  out  1  registered id_next_delay fed back to decode.
REQ-015 perf_clr  in  1  synchronous clear of performance counters.
REQ-016 stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters (present only with macro, REQ-030).

Function
REQ-017 Each edge SHALL apply exactly one action, priority: rst > flush > bubble > hold > capture.
REQ-018 Flush (flush=1): all ex_* outputs and id_is_in_delayslot SHALL become 0.
REQ-019 Bubble (control[STALL_IDX]=1, control[STALL_IDX+1]=0): all ex_* outputs SHALL become 0, ex_valid=0; id_is_in_delayslot SHALL hold.
REQ-020 Hold (control[STALL_IDX]=1, control[STALL_IDX+1]=1): every output SHALL keep its value.
REQ-021 Capture (control[STALL_IDX]=0): every ex_* output SHALL take its id_* input, ex_valid<=id_valid, id_is_in_delayslot<=id_next_delay.
REQ-022 control[STALL_IDX]=0 with control[STALL_IDX+1]=1 SHALL still capture (upstream bug; verification flags it via assertion, RTL does not special-case).
REQ-023 Latency SHALL be exactly one cycle from input to output; no combinational input-to-output path.
REQ-024 Control bits outside STALL_IDX and STALL_IDX+1 SHALL be ignored.

Reset
REQ-025 On rst=1 at an edge, every output (all ex_*, id_is_in_delayslot, all counters) SHALL become 0, regardless of flush/control/perf_clr.
REQ-026 Reset asserted mid-stall SHALL discard held contents; first capture after release takes the then-current inputs.
REQ-027 No output SHALL be X after the first reset edge.

Configuration
REQ-028 Macro ID_EX_PERF_CNT_EN SHALL gate the performance counters.
REQ-029 Without macro: stall_cnt, bubble_cnt, flush_cnt ports absent, perf_clr port absent, no counter flops.
REQ-030 With macro: stall_cnt +1 each edge with control[STALL_IDX]=1 and flush=0; bubble_cnt +1 per bubble; flush_cnt +1 per flush; all saturate at 2^CNT_W-1; perf_clr=1 sets all to 0, overriding increments; flush with stall counts flush only.

Verification
REQ-031 Reset then capture: rst 1 cycle, id_op1=0x12345678, id_dest=5, id_wreg=1, control=0 -> next edge ex_op1=0x12345678, ex_dest=5, ex_wreg=1, ex_valid=1.
REQ-032 Hold: capture id_ins=0xAABBCCDD, then control=6'b001100 for 3 cycles with changing inputs -> ex_ins stays 0xAABBCCDD all 3 cycles.
REQ-033 Bubble: control=6'b000100, id_valid=1, id_next_delay=1 previously captured -> ex_valid=0, ex_aluop=0, id_is_in_delayslot stays 1.
REQ-034 Flush beats stall: flush=1, control=6'b001100 -> all ex_* 0, id_is_in_delayslot=0; with macro flush_cnt=1, stall_cnt unchanged.
REQ-035 Saturation (macro, CNT_W=4): 20 stall cycles -> stall_cnt=15; perf_clr=1 with stall -> stall_cnt=0.
REQ-036 Parameter sweep: DATA_W=64, STALL_IDX=4 -> REQ-031..033 pass using control[4]/control[5].
